// File: rtl/spi_slave_frame_engine_if.sv
// ---------------------------------------------------------------------------
// spi_slave_frame_engine_if
// Purpose : bundles the SPI pins (SS_n/MOSI/MISO) and the RAM-side rx/tx
//           handshake of the SPI slave frame engine into one interface.
// Signals : SS_n, MOSI      - from the external SPI master
//           MISO            - serial read data back to the master
//           rx_data/rx_valid- completed frame {cmd, payload} and its strobe
//           tx_data/tx_valid- read data offered by the RAM side
//           busy, frame_err - engine status
// Modports: slave  - the frame engine side
//           master - the environment (SPI master + RAM) side
// ---------------------------------------------------------------------------
interface spi_slave_frame_engine_if #(
  parameter int unsigned DATA_W = 8
);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              busy;
  logic              frame_err;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, busy, frame_err
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, busy, frame_err
  );
endinterface

// File: rtl/spi_slave_frame_engine.sv
// ---------------------------------------------------------------------------
// spi_slave_frame_engine
// Purpose : SPI slave frame engine. Receives a path bit plus a
//           (DATA_W+2)-bit frame {cmd[1:0], payload} MSB first, validates the
//           command against the path, publishes completed frames on
//           rx_data/rx_valid and, after a read-data frame, waits for tx_valid
//           and shifts tx_data out on MISO MSB first. Aborted (SS_n raised
//           early) and malformed frames pulse frame_err.
// Ports   : clk   - system clock, SPI pins sampled on its rising edge
//           rst_n - asynchronous active-low reset
//           bus   - spi_slave_frame_engine_if.slave (SPI pins, rx/tx, status)
// Params  : DATA_W    - payload width (4..32)
//           MISO_IDLE - MISO level whenever read data is not being shifted
// ---------------------------------------------------------------------------
module spi_slave_frame_engine #(
  parameter int unsigned DATA_W    = 8,
  parameter logic        MISO_IDLE = 1'b0
) (
  input logic                     clk,
  input logic                     rst_n,
  spi_slave_frame_engine_if.slave bus
);

  localparam int unsigned FRAME_W = DATA_W + 2;
  localparam logic [5:0]  LAST_RX = 6'(FRAME_W - 1);
  localparam logic [5:0]  LAST_TX = 6'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CHK_CMD, ST_WRITE, ST_READ_ADD,
    ST_READ_DATA, ST_READ_WAIT, ST_SHIFT_OUT, ST_DONE
  } state_e;

  state_e               state_q;
  logic [5:0]           cnt_q;
  logic                 rd_flag_q;
  logic [FRAME_W-2:0]   rx_sh_q;     // top bit is never needed: the frame completes on MOSI directly
  logic [FRAME_W-1:0]   rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic [DATA_W-1:0]    tx_sh_q;
  logic                 miso_q;

  logic [FRAME_W-1:0]   rx_word;
  logic                 cmd_ok;

  // Frame as it stands including the bit on MOSI this cycle, and whether its
  // command field matches the path chosen in CHK_CMD.
  always_comb begin
    rx_word = {rx_sh_q, bus.MOSI};
    cmd_ok  = 1'b0;
    case (state_q)
      ST_WRITE:     cmd_ok = (rx_word[FRAME_W-1] == 1'b0);
      ST_READ_ADD:  cmd_ok = (rx_word[FRAME_W-1 -: 2] == 2'b10);
      ST_READ_DATA: cmd_ok = (rx_word[FRAME_W-1 -: 2] == 2'b11);
      default:      cmd_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rd_flag_q   <= 1'b0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tx_sh_q     <= '0;
      miso_q      <= MISO_IDLE;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (state_q != ST_IDLE && bus.SS_n) begin
        // SS_n deasserted: only legal once the frame is DONE, anything
        // earlier (including on the final bit) is an abort.
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        miso_q  <= MISO_IDLE;
        if (state_q != ST_DONE) frame_err_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!bus.SS_n) state_q <= ST_CHK_CMD;
          end
          ST_CHK_CMD: begin
            cnt_q <= '0;
            if (!bus.MOSI)     state_q <= ST_WRITE;
            else if (rd_flag_q) state_q <= ST_READ_DATA;
            else                state_q <= ST_READ_ADD;
          end
          ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
            rx_sh_q <= rx_word[FRAME_W-2:0];
            if (cnt_q == LAST_RX) begin
              cnt_q   <= '0;
              state_q <= ST_DONE;
              if (cmd_ok) begin
                rx_data_q  <= rx_word;
                rx_valid_q <= 1'b1;
                if (state_q == ST_READ_ADD) rd_flag_q <= 1'b1;
                if (state_q == ST_READ_DATA) begin
                  rd_flag_q <= 1'b0;
                  state_q   <= ST_READ_WAIT;
                end
              end else begin
                frame_err_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          ST_READ_WAIT: begin
            // MSB goes straight to MISO so it is valid right after this edge.
            if (bus.tx_valid) begin
              miso_q  <= bus.tx_data[DATA_W-1];
              tx_sh_q <= {bus.tx_data[DATA_W-2:0], 1'b0};
              cnt_q   <= '0;
              state_q <= ST_SHIFT_OUT;
            end
          end
          ST_SHIFT_OUT: begin
            if (cnt_q == LAST_TX) begin
              miso_q  <= MISO_IDLE;
              cnt_q   <= '0;
              state_q <= ST_DONE;
            end else begin
              miso_q  <= tx_sh_q[DATA_W-1];
              tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
              cnt_q   <= cnt_q + 6'd1;
            end
          end
          ST_DONE: ;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.MISO      = miso_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_frame_engine.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_frame_engine
// Directed bench: one engine at DATA_W=8 and one at DATA_W=16 share clock,
// reset and MOSI but have separate slave selects.
// ---------------------------------------------------------------------------
module tb_spi_slave_frame_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ss8_n = 1'b1;
  logic ss16_n = 1'b1;
  logic mosi = 1'b0;
  logic [7:0] tx8_data = '0;
  logic tx8_valid = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_slave_frame_engine_if #(.DATA_W(8))  if8 ();
  spi_slave_frame_engine_if #(.DATA_W(16)) if16 ();

  assign if8.SS_n      = ss8_n;
  assign if8.MOSI      = mosi;
  assign if8.tx_data   = tx8_data;
  assign if8.tx_valid  = tx8_valid;
  assign if16.SS_n     = ss16_n;
  assign if16.MOSI     = mosi;
  assign if16.tx_data  = 16'h0000;
  assign if16.tx_valid = 1'b0;

  spi_slave_frame_engine #(.DATA_W(8), .MISO_IDLE(1'b0)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(if8.slave)
  );
  spi_slave_frame_engine #(.DATA_W(16), .MISO_IDLE(1'b0)) u16 (
    .clk(clk), .rst_n(rst_n), .bus(if16.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lowers SS_n, sends the path bit, then the first nbits of the frame
  // (MSB first). Returns 1 time unit after the last driven edge.
  task automatic frame(input bit wide, input logic path, input logic [17:0] bits, input int nbits);
    int n;
    n = wide ? 18 : 10;
    if (wide) ss16_n = 1'b0; else ss8_n = 1'b0;
    tick();                     // E0
    mosi = path;
    tick();                     // E1
    for (int i = 0; i < nbits; i++) begin
      mosi = bits[n-1-i];
      tick();
    end
  endtask

  task automatic end8();
    ss8_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] txv;

    // Reset state
    tick(); tick();
    chk("rst_rx_data",  64'(if8.rx_data), 64'h0);
    chk("rst_rx_valid", 64'(if8.rx_valid), 64'h0);
    chk("rst_busy",     64'(if8.busy), 64'h0);
    chk("rst_ferr",     64'(if8.frame_err), 64'h0);
    chk("rst_miso",     64'(if8.MISO), 64'h0);
    rst_n = 1'b1;
    tick();

    // Write frame 0, 00_1010_0101
    frame(1'b0, 1'b0, 18'h0A5, 9);
    chk("wr_busy",       64'(if8.busy), 64'h1);
    chk("wr_no_early_v", 64'(if8.rx_valid), 64'h0);
    mosi = 1'b1;
    tick();                                          // E11
    chk("wr_rx_valid", 64'(if8.rx_valid), 64'h1);
    chk("wr_rx_data",  64'(if8.rx_data), 64'h0A5);
    chk("wr_ferr",     64'(if8.frame_err), 64'h0);
    chk("wr_rd_flag",  64'(u8.rd_flag_q), 64'h0);
    tick();
    chk("wr_v_pulse",  64'(if8.rx_valid), 64'h0);
    chk("wr_busy_done",64'(if8.busy), 64'h1);
    end8();
    chk("wr_idle",     64'(if8.busy), 64'h0);
    chk("wr_no_err",   64'(if8.frame_err), 64'h0);

    // Read address frame
    frame(1'b0, 1'b1, 18'h23C, 10);
    chk("ra_rx_valid", 64'(if8.rx_valid), 64'h1);
    chk("ra_rx_data",  64'(if8.rx_data), 64'h23C);
    chk("ra_rd_flag",  64'(u8.rd_flag_q), 64'h1);
    end8();

    // Read data frame then shift out 0xC3
    frame(1'b0, 1'b1, 18'h355, 10);
    chk("rd_rx_valid", 64'(if8.rx_valid), 64'h1);
    chk("rd_cmd",      64'(if8.rx_data[9:8]), 64'h3);
    chk("rd_rd_flag",  64'(u8.rd_flag_q), 64'h0);
    tick();
    chk("rd_wait_miso", 64'(if8.MISO), 64'h0);
    tick();
    chk("rd_wait_busy", 64'(if8.busy), 64'h1);
    txv = 8'hC3;
    tx8_data = txv;
    tx8_valid = 1'b1;
    tick();                                          // Et
    tx8_valid = 1'b0;
    chk("rd_miso_b7", 64'(if8.MISO), 64'(txv[7]));
    for (int k = 6; k >= 0; k--) begin
      tick();
      chk($sformatf("rd_miso_b%0d", k), 64'(if8.MISO), 64'(txv[k]));
    end
    tick();
    chk("rd_miso_idle", 64'(if8.MISO), 64'h0);
    chk("rd_done_busy", 64'(if8.busy), 64'h1);
    end8();
    chk("rd_idle",      64'(if8.busy), 64'h0);
    chk("rd_no_err",    64'(if8.frame_err), 64'h0);

    // Abort: SS_n rises after E6 of a write
    frame(1'b0, 1'b0, 18'h0FF, 5);
    ss8_n = 1'b1;
    tick();                                          // E7
    chk("ab_ferr",     64'(if8.frame_err), 64'h1);
    chk("ab_rx_valid", 64'(if8.rx_valid), 64'h0);
    chk("ab_rx_data",  64'(if8.rx_data), 64'h355);
    chk("ab_busy",     64'(if8.busy), 64'h0);
    tick();
    chk("ab_ferr_pulse", 64'(if8.frame_err), 64'h0);

    // Mismatch with rd_flag set: read address first, then path 0 with cmd 11
    frame(1'b0, 1'b1, 18'h2AA, 10);
    chk("mm_setup_v", 64'(if8.rx_valid), 64'h1);
    end8();
    frame(1'b0, 1'b0, 18'h30F, 10);
    chk("mm_ferr",     64'(if8.frame_err), 64'h1);
    chk("mm_rx_valid", 64'(if8.rx_valid), 64'h0);
    chk("mm_rx_data",  64'(if8.rx_data), 64'h2AA);
    chk("mm_rd_flag",  64'(u8.rd_flag_q), 64'h1);
    end8();
    chk("mm_no_err",   64'(if8.frame_err), 64'h0);

    // Reset during SHIFT_OUT (read data, tx_valid already in rx_valid cycle)
    frame(1'b0, 1'b1, 18'h3FF, 10);
    chk("rs_rx_valid", 64'(if8.rx_valid), 64'h1);
    tx8_data = 8'hA5;
    tx8_valid = 1'b1;
    tick();                                          // Et
    tx8_valid = 1'b0;
    chk("rs_miso_b7", 64'(if8.MISO), 64'h1);
    tick();
    chk("rs_miso_b6", 64'(if8.MISO), 64'h0);
    tick();
    chk("rs_miso_b5", 64'(if8.MISO), 64'h1);
    rst_n = 1'b0;
    #2;
    chk("rs_miso",    64'(if8.MISO), 64'h0);
    chk("rs_busy",    64'(if8.busy), 64'h0);
    chk("rs_rd_flag", 64'(u8.rd_flag_q), 64'h0);
    chk("rs_rx_data", 64'(if8.rx_data), 64'h0);
    ss8_n = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    frame(1'b0, 1'b1, 18'h2C3, 10);                  // must land in READ_ADD
    chk("rs_ra_valid", 64'(if8.rx_valid), 64'h1);
    chk("rs_ra_data",  64'(if8.rx_data), 64'h2C3);
    chk("rs_ra_ferr",  64'(if8.frame_err), 64'h0);
    end8();

    // SS_n rising on the final bit edge: abort wins
    frame(1'b0, 1'b0, 18'h055, 9);
    mosi = 1'b1;
    ss8_n = 1'b1;
    tick();
    chk("lb_ferr",     64'(if8.frame_err), 64'h1);
    chk("lb_rx_valid", 64'(if8.rx_valid), 64'h0);
    chk("lb_rx_data",  64'(if8.rx_data), 64'h2C3);
    chk("lb_busy",     64'(if8.busy), 64'h0);
    tick();

    // DATA_W=16 write frame, 01_1011_0011_1100_0101
    frame(1'b1, 1'b0, 18'h1B3C5, 17);                // through E18
    chk("w16_no_early_v", 64'(if16.rx_valid), 64'h0);
    mosi = 1'b1;
    tick();                                          // E19
    chk("w16_rx_valid", 64'(if16.rx_valid), 64'h1);
    chk("w16_rx_data",  64'(if16.rx_data), 64'h1B3C5);
    chk("w16_ferr",     64'(if16.frame_err), 64'h0);
    chk("w16_u8_quiet", 64'(if8.rx_valid), 64'h0);
    ss16_n = 1'b1;
    tick();
    chk("w16_idle",     64'(if16.busy), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
